// File: rtl/slurm16_cpu_mem_arbiter_pkg.sv
// Shared definitions for the SLURM16 CPU-side memory arbiter.
// Contents: FSM state encoding, channel-count limit, pointer-width helper.
package slurm16_cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int MAX_CHANNELS = 8;

    // Width of a channel index / round-robin pointer; never narrower than 1 bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slurm16_rr_picker.sv
// Request picker: finds the first asserted request searching upward from a
// start pointer, wrapping modulo CHANNELS.
// Ports:
//   i_req   - per-channel request vector
//   i_ptr   - search start (ignored when ROUND_ROBIN=0, search starts at 0)
//   o_grant - one-hot winner (all zero when no request)
//   o_idx   - index of the winner
//   o_any   - at least one request present
module slurm16_rr_picker #(
    parameter int CHANNELS    = 2,
    parameter int ROUND_ROBIN = 0,
    parameter int PTR_W       = 1
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [PTR_W-1:0]    i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [PTR_W-1:0]    o_idx,
    output logic                o_any
);

    int                w_base;
    logic [PTR_W-1:0]  w_cand;

    // Circular first-one search starting at the (effective) pointer.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        w_base  = (ROUND_ROBIN != 0) ? int'(i_ptr) : 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand = PTR_W'((w_base + k) % CHANNELS);
            if (!o_any && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                o_any           = 1'b1;
            end else begin
                // winner already found or channel idle: keep current result
            end
        end
    end

endmodule

// File: rtl/slurm16_cpu_mem_arbiter.sv
// SLURM16 CPU memory arbiter: merges CHANNELS requesters onto the single
// memory bus, one outstanding access at a time (IDLE -> BUSY -> DONE).
// Ports:
//   CLK, RSTb                     - clock, async active-low reset
//   ch_valid/ch_wr/ch_addr/
//   ch_data/ch_mask               - per-channel request (packed per channel)
//   ch_accept                     - one-hot, request captured this cycle
//   ch_resp_valid/ch_resp_data    - one-hot completion pulse, read data
//   memory_*                      - SLURM16 bus (valid/ready handshake)
//   halt_req/halted               - stop granting; reports idle while halted
module slurm16_cpu_mem_arbiter
    import slurm16_cpu_mem_arbiter_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int CHANNELS     = 2,
    parameter int ROUND_ROBIN  = 0
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic [CHANNELS-1:0]          ch_valid,
    input  logic [CHANNELS-1:0]          ch_wr,
    input  logic [CHANNELS*ADDRESS_BITS-1:0] ch_addr,
    input  logic [CHANNELS*BITS-1:0]     ch_data,
    input  logic [CHANNELS*2-1:0]        ch_mask,
    output logic [CHANNELS-1:0]          ch_accept,
    output logic [CHANNELS-1:0]          ch_resp_valid,
    output logic [BITS-1:0]              ch_resp_data,
    output logic [ADDRESS_BITS-1:0]      memory_address,
    output logic [BITS-1:0]              memory_out,
    output logic                         memory_wr,
    output logic [1:0]                   memory_wr_mask,
    output logic                         memory_valid,
    input  logic                         memory_ready,
    input  logic [BITS-1:0]              memory_in,
    input  logic                         halt_req,
    output logic                         halted
);

    localparam int PTR_W = ptr_width(CHANNELS);

    arb_state_t               r_state;
    logic [PTR_W-1:0]         r_owner;
    logic [PTR_W-1:0]         r_ptr;
    logic [ADDRESS_BITS-1:0]  r_addr;
    logic [BITS-1:0]          r_data;
    logic [1:0]               r_mask;
    logic                     r_wr;
    logic                     r_mem_valid;
    logic [CHANNELS-1:0]      r_resp_valid;

    logic [CHANNELS-1:0]      w_grant;
    logic [PTR_W-1:0]         w_idx;
    logic                     w_any;
    logic                     w_take;

    slurm16_rr_picker #(
        .CHANNELS    (CHANNELS),
        .ROUND_ROBIN (ROUND_ROBIN),
        .PTR_W       (PTR_W)
    ) u_picker (
        .i_req   (ch_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A grant happens only from IDLE, with halt released and something pending.
    assign w_take    = (r_state == ST_IDLE) && !halt_req && w_any;
    assign ch_accept = w_take ? w_grant : '0;
    assign halted    = halt_req && (r_state == ST_IDLE);

    // Synchronous memory: read data arrives in the cycle after ready, so it is
    // passed straight through while the completion pulse is high.
    assign ch_resp_data = (r_state == ST_DONE) ? memory_in : '0;

    assign memory_address = r_addr;
    assign memory_out     = r_data;
    assign memory_wr      = r_wr;
    assign memory_wr_mask = r_mask;
    assign memory_valid   = r_mem_valid;
    assign ch_resp_valid  = r_resp_valid;

    // Access FSM with capture registers and round-robin pointer.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_ptr        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= 2'b00;
            r_wr         <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner     <= w_idx;
                        r_addr      <= ch_addr[w_idx*ADDRESS_BITS +: ADDRESS_BITS];
                        r_data      <= ch_data[w_idx*BITS +: BITS];
                        r_mask      <= ch_mask[w_idx*2 +: 2];
                        r_wr        <= ch_wr[w_idx];
                        r_mem_valid <= 1'b1;
                        r_state     <= ST_BUSY;
                        // Rotate so the winner becomes lowest priority next time.
                        if (int'(w_idx) == CHANNELS - 1) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= w_idx + 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (memory_ready) begin
                        r_mem_valid  <= 1'b0;
                        r_resp_valid <= CHANNELS'(1) << r_owner;
                        r_state      <= ST_DONE;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    r_resp_valid <= '0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_mem_valid  <= 1'b0;
                    r_resp_valid <= '0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
